// File: rtl/lpc_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lpc_reg_pkg
// Purpose  : Shared types and helpers for the LPC register bank: lock-state
//            encoding, key values, register access modes and address decode.
// Revision : 1.0 - initial release
// ============================================================================
package lpc_reg_pkg;

    // Lock FSM states. The encoding is visible to software through the key
    // register, so the values are fixed.
    typedef enum logic [1:0] {
        LS_LOCKED   = 2'd0,
        LS_KEY1     = 2'd1,
        LS_UNLOCKED = 2'd2
    } lock_state_e;

    localparam logic [7:0] KEY1_VAL = 8'h55;
    localparam logic [7:0] KEY2_VAL = 8'hAA;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_RO  = 2'd1,
        ACC_W1C = 2'd2
    } acc_mode_e;

    // RO takes precedence over W1C when both mask bits are set.
    function automatic acc_mode_e acc_mode(input logic ro, input logic w1c);
        if (ro)  return ACC_RO;
        if (w1c) return ACC_W1C;
        return ACC_RW;
    endfunction

    // Address decode. Once addr >= base holds, addr - base cannot wrap, so
    // doing the subtraction at 32 bits gives the same offset as at ADDR_W bits.
    function automatic logic decode_hit(input int unsigned addr,
                                        input int unsigned base,
                                        input int unsigned num);
        return (addr >= base) && ((addr - base) < num);
    endfunction

    function automatic int unsigned decode_ofs(input int unsigned addr,
                                               input int unsigned base);
        return addr - base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_reg_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : lpc_reg_lock_fsm
// Purpose  : Key-sequence write lock (55h then AAh to the key register) with
//            an idle counter that relocks the bank after LOCK_TIMEOUT cycles.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_key_wr        - decoded write to the key register
//            i_hit_wr        - any write that hits the bank
//            i_data[7:0]     - low byte of the write data
//            o_state         - current lock state
//            o_unlocked      - 1 when RW writes are allowed
// Revision : 1.0 - initial release
// ============================================================================
module lpc_reg_lock_fsm
    import lpc_reg_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_key_wr,
    input  logic        i_hit_wr,
    input  logic [7:0]  i_data,
    output lock_state_e o_state,
    output logic        o_unlocked
);

    localparam int              CNT_W     = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    lock_state_e      r_state;
    lock_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LS_LOCKED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        case (r_state)
            LS_LOCKED: begin
                if (i_key_wr && (i_data == KEY1_VAL))
                    w_state_next = LS_KEY1;
            end
            LS_KEY1: begin
                // Any hit write other than the second key aborts the sequence.
                if (i_hit_wr)
                    w_state_next = (i_key_wr && (i_data == KEY2_VAL)) ? LS_UNLOCKED : LS_LOCKED;
            end
            LS_UNLOCKED: begin
                // A non-key write in the expiry cycle counts as activity and
                // keeps the bank open; the counter then starts over.
                if (i_key_wr)
                    w_state_next = LS_LOCKED;
                else if (!i_hit_wr && (r_cnt == c_CNT_MAX))
                    w_state_next = LS_LOCKED;
            end
            default: w_state_next = LS_LOCKED;
        endcase

        // Counter only runs while staying in UNLOCKED; entry and writes clear it.
        if ((w_state_next != LS_UNLOCKED) || (r_state != LS_UNLOCKED) || i_hit_wr)
            w_cnt_next = '0;
        else if (r_cnt != c_CNT_MAX)
            w_cnt_next = r_cnt + 1'b1;
    end

    assign o_state    = r_state;
    assign o_unlocked = (r_state == LS_UNLOCKED);

endmodule
`default_nettype wire

// File: rtl/lpc_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : lpc_reg_bank
// Purpose  : Parametrised LPC-side register bank with per-register access
//            mode (RW / RO from hardware / W1C sticky), registered reads with
//            a valid strobe, and a key-sequence write lock for RW registers.
// Ports    : LpcClock, PciReset  - clock, asynchronous active-high reset
//            Addr, Rd, Wr, DataWr - LPC-side access strobes and write data
//            DataRd, RdValid      - registered read data and its 1-cycle strobe
//            HwValue, HwSet       - live RO values, W1C set pulses
//            RegOut               - flat view of all registers (key slot = 0)
//            Locked, LockViol     - lock status, dropped-write pulse
// Revision : 1.0 - initial release
// ============================================================================
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int                         DATA_W       = 8,
    parameter int                         ADDR_W       = 8,
    parameter int                         NUM_REGS     = 32,
    parameter int                         BASE_ADDR    = 0,
    parameter logic [7:0]                 ID_VALUE     = 8'h00,
    parameter int                         KEY_OFS      = NUM_REGS - 1,
    parameter logic [NUM_REGS-1:0]        RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0,
    parameter int                         LOCK_TIMEOUT = 1024
) (
    input  logic                       LpcClock,
    input  logic                       PciReset,
    input  logic [ADDR_W-1:0]          Addr,
    input  logic                       Rd,
    input  logic                       Wr,
    input  logic [DATA_W-1:0]          DataWr,
    output logic [DATA_W-1:0]          DataRd,
    output logic                       RdValid,
    input  logic [NUM_REGS*DATA_W-1:0] HwValue,
    input  logic [NUM_REGS*DATA_W-1:0] HwSet,
    output logic [NUM_REGS*DATA_W-1:0] RegOut,
    output logic                       Locked,
    output logic                       LockViol
);

    localparam logic [DATA_W-1:0] c_ALL_ONES = '1;

    logic                w_hit;
    logic [ADDR_W-1:0]   w_ofs;
    logic                w_hit_wr;
    logic                w_key_wr;
    lock_state_e         w_state;
    logic                w_unlocked;
    logic [NUM_REGS-1:0] w_wsel;
    logic [NUM_REGS-1:0] w_rw_bit;
    logic [DATA_W-1:0]   w_view [NUM_REGS];
    logic [DATA_W-1:0]   w_rd_sel;
    logic                w_viol;

    logic [DATA_W-1:0]   r_data_rd;
    logic                r_rd_valid;
    logic                r_lock_viol;

    assign w_hit    = decode_hit(32'(Addr), 32'(BASE_ADDR), 32'(NUM_REGS));
    assign w_ofs    = ADDR_W'(decode_ofs(32'(Addr), 32'(BASE_ADDR)));
    assign w_hit_wr = Wr && w_hit;
    assign w_key_wr = w_hit_wr && (w_ofs == ADDR_W'(KEY_OFS));

    lpc_reg_lock_fsm #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock (
        .clk        (LpcClock),
        .rst        (PciReset),
        .i_key_wr   (w_key_wr),
        .i_hit_wr   (w_hit_wr),
        .i_data     (DataWr[7:0]),
        .o_state    (w_state),
        .o_unlocked (w_unlocked)
    );

    // Per-register storage. Offset 0 and the key slot have no storage of
    // their own; the key register is the lock FSM.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam acc_mode_e c_MODE = acc_mode(RO_MASK[gi], W1C_MASK[gi]);

        assign w_wsel[gi] = w_hit_wr && (w_ofs == ADDR_W'(gi));

        if (gi == 0) begin : g_id
            assign w_view[gi]   = DATA_W'(ID_VALUE);
            assign w_rw_bit[gi] = 1'b0;
        end else if (gi == KEY_OFS) begin : g_key
            assign w_view[gi]   = '0;
            assign w_rw_bit[gi] = 1'b0;
        end else if (c_MODE == ACC_RO) begin : g_ro
            assign w_view[gi]   = HwValue[gi*DATA_W +: DATA_W];
            assign w_rw_bit[gi] = 1'b0;
        end else if (c_MODE == ACC_W1C) begin : g_w1c
            logic [DATA_W-1:0] r_val;
            // Set is OR-ed in after the clear, so a same-cycle set wins.
            always_ff @(posedge LpcClock or posedge PciReset) begin
                if (PciReset)
                    r_val <= '0;
                else if (w_wsel[gi])
                    r_val <= (r_val & ~DataWr) | HwSet[gi*DATA_W +: DATA_W];
                else
                    r_val <= r_val | HwSet[gi*DATA_W +: DATA_W];
            end
            assign w_view[gi]   = r_val;
            assign w_rw_bit[gi] = 1'b0;
        end else begin : g_rw
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge LpcClock or posedge PciReset) begin
                if (PciReset)
                    r_val <= RESET_VALUES[gi*DATA_W +: DATA_W];
                else if (w_wsel[gi] && w_unlocked)
                    r_val <= DataWr;
            end
            assign w_view[gi]   = r_val;
            assign w_rw_bit[gi] = 1'b1;
        end

        assign RegOut[gi*DATA_W +: DATA_W] = w_view[gi];
    end

    // Single read mux; the key slot reports the lock state instead of its
    // zero view.
    always_comb begin
        w_rd_sel = c_ALL_ONES;
        if (w_hit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_ofs == ADDR_W'(i))
                    w_rd_sel = w_view[i];
            end
            if (w_ofs == ADDR_W'(KEY_OFS))
                w_rd_sel = DATA_W'(w_state);
        end
    end

    assign w_viol = !w_unlocked && (|(w_wsel & w_rw_bit));

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            r_data_rd   <= c_ALL_ONES;
            r_rd_valid  <= 1'b0;
            r_lock_viol <= 1'b0;
        end else begin
            r_rd_valid  <= Rd;
            r_lock_viol <= w_viol;
            if (Rd)
                r_data_rd <= w_rd_sel;
        end
    end

    assign DataRd   = r_data_rd;
    assign RdValid  = r_rd_valid;
    assign LockViol = r_lock_viol;
    assign Locked   = !w_unlocked;

    // HwValue/HwSet slices of non-RO / non-W1C registers are intentionally
    // ignored.
    logic w_unused;
    assign w_unused = ^{HwValue, HwSet};

endmodule
`default_nettype wire
